// File: rtl/ls_unit.sv
// ls_unit: single-transaction load/store engine between register file and data memory.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_start, i_isLoad, i_loadType       operation request (sampled in IDLE only)
//   i_baseAddr, i_offset                address operands (indexed adds offset, wraps mod 256)
//   i_storeData, i_destReg              store operand, load write-back register
//   o_busy                              high whenever not IDLE
//   o_memReq/We/Addr/Wdata, i_memAck,
//   i_memRdata                          request/acknowledge memory port
//   o_isLoad, o_addrRw, o_dataIn        one-cycle register-file write-back for loads
//   o_done, o_fault                     completion / timeout-abort pulses
module ls_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_isLoad,
  input  logic       i_loadType,
  input  logic [7:0] i_baseAddr,
  input  logic [7:0] i_offset,
  input  logic [7:0] i_storeData,
  input  logic [2:0] i_destReg,
  output logic       o_busy,
  output logic       o_memReq,
  output logic       o_memWe,
  output logic [7:0] o_memAddr,
  output logic [7:0] o_memWdata,
  input  logic       i_memAck,
  input  logic [7:0] i_memRdata,
  output logic       o_isLoad,
  output logic [2:0] o_addrRw,
  output logic [7:0] o_dataIn,
  output logic       o_done,
  output logic       o_fault
);
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0] data_in_q, data_in_d;
  logic [2:0] dest_q, dest_d, addr_rw_q, addr_rw_d;
  logic busy_q, busy_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic is_load_q, is_load_d, done_q, done_d, fault_q, fault_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    dest_d = dest_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_rw_d = addr_rw_q;
    data_in_d = data_in_q;
    is_load_d = 1'b0;
    done_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = REQ;
        cnt_d = 8'd0;
        mem_req_d = 1'b1;
        mem_we_d = ~i_isLoad;
        mem_addr_d = i_loadType ? i_baseAddr + i_offset : i_baseAddr;
        mem_wdata_d = i_storeData;
        dest_d = i_destReg;
      end
      REQ: if (i_memAck) begin
        // ack beats a timeout landing in the same cycle
        mem_req_d = 1'b0;
        state_d = mem_we_q ? IDLE : WB;
        done_d = mem_we_q;
        rdata_d = mem_we_q ? rdata_q : i_memRdata;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        mem_req_d = 1'b0;
        fault_d = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      WB: begin
        // write-back strobe is registered on leaving WB so it coincides with the
        // cycle the unit is idle again and can accept the next start
        state_d = IDLE;
        is_load_d = 1'b1;
        addr_rw_d = dest_q;
        data_in_d = rdata_q;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      rdata_q <= 8'd0;
      dest_q <= 3'd0;
      busy_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= 8'd0;
      mem_wdata_q <= 8'd0;
      is_load_q <= 1'b0;
      addr_rw_q <= 3'd0;
      data_in_q <= 8'd0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      dest_q <= dest_d;
      busy_q <= busy_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      is_load_q <= is_load_d;
      addr_rw_q <= addr_rw_d;
      data_in_q <= data_in_d;
      done_q <= done_d;
      fault_q <= fault_d;
    end
  end
  assign o_busy = busy_q;
  assign o_memReq = mem_req_q;
  assign o_memWe = mem_we_q;
  assign o_memAddr = mem_addr_q;
  assign o_memWdata = mem_wdata_q;
  assign o_isLoad = is_load_q;
  assign o_addrRw = addr_rw_q;
  assign o_dataIn = data_in_q;
  assign o_done = done_q;
  assign o_fault = fault_q;
endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: directed self-checking bench for ls_unit.
module tb_ls_unit;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_isLoad = 1'b0, i_loadType = 1'b0, i_memAck = 1'b0;
  logic [7:0] i_baseAddr = 8'd0, i_offset = 8'd0, i_storeData = 8'd0, i_memRdata = 8'd0;
  logic [2:0] i_destReg = 3'd0;
  logic o_busy, o_memReq, o_memWe, o_isLoad, o_done, o_fault;
  logic [7:0] o_memAddr, o_memWdata, o_dataIn;
  logic [2:0] o_addrRw;
  int checks = 0, failures = 0;
  ls_unit #(.TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_isLoad(i_isLoad), .i_loadType(i_loadType),
    .i_baseAddr(i_baseAddr), .i_offset(i_offset), .i_storeData(i_storeData), .i_destReg(i_destReg),
    .o_busy(o_busy), .o_memReq(o_memReq), .o_memWe(o_memWe), .o_memAddr(o_memAddr), .o_memWdata(o_memWdata),
    .i_memAck(i_memAck), .i_memRdata(i_memRdata), .o_isLoad(o_isLoad), .o_addrRw(o_addrRw),
    .o_dataIn(o_dataIn), .o_done(o_done), .o_fault(o_fault)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [32:0] outs();
    return {o_busy, o_memReq, o_memWe, o_memAddr, o_memWdata, o_isLoad, o_addrRw, o_dataIn, o_done, o_fault};
  endfunction
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic drive_start(input logic ld, input logic lt, input logic [7:0] base, input logic [7:0] off,
                             input logic [7:0] sd, input logic [2:0] dest);
    i_start = 1'b1; i_isLoad = ld; i_loadType = lt; i_baseAddr = base; i_offset = off; i_storeData = sd; i_destReg = dest;
  endtask
  task automatic test_reset();
    tick();
    checks++;
    if (outs() !== 33'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", outs()); end
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (outs() !== 33'd0) begin failures++; $display("FAIL idle_after_reset got=%h want=0", outs()); end
  endtask
  task automatic test_direct_load();
    drive_start(1'b1, 1'b0, 8'h12, 8'h77, 8'h00, 3'd5);
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_busy, o_memReq, o_memWe, o_memAddr} !== {1'b1, 1'b1, 1'b0, 8'h12})
      begin failures++; $display("FAIL load_req busy/req/we/addr got=%b%b%b/%h want=110/12", o_busy, o_memReq, o_memWe, o_memAddr); end
    i_memAck = 1'b1; i_memRdata = 8'hA7;
    tick();
    i_memAck = 1'b0; i_memRdata = 8'h00;
    checks++;
    if ({o_busy, o_memReq, o_isLoad, o_done} !== 4'b1000)
      begin failures++; $display("FAIL load_wb_state busy/req/isLoad/done got=%b want=1000", {o_busy, o_memReq, o_isLoad, o_done}); end
    tick();
    checks++;
    if ({o_isLoad, o_addrRw, o_dataIn, o_done, o_busy, o_fault} !== {1'b1, 3'd5, 8'hA7, 1'b1, 1'b0, 1'b0})
      begin failures++; $display("FAIL load_writeback isLoad=%b addrRw=%0d dataIn=%h done=%b busy=%b want 1/5/a7/1/0", o_isLoad, o_addrRw, o_dataIn, o_done, o_busy); end
    tick();
    checks++;
    if ({o_isLoad, o_done, o_dataIn, o_addrRw} !== {1'b0, 1'b0, 8'hA7, 3'd5})
      begin failures++; $display("FAIL load_hold isLoad=%b done=%b dataIn=%h addrRw=%0d want 0/0/a7/5", o_isLoad, o_done, o_dataIn, o_addrRw); end
  endtask
  task automatic test_indexed_store();
    logic bad = 1'b0;
    drive_start(1'b0, 1'b1, 8'hF0, 8'h20, 8'h3C, 3'd2);
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({o_memReq, o_memWe, o_memAddr, o_memWdata, o_isLoad, o_done} !== {1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 1'b0}) begin
        bad = 1'b1;
        $display("FAIL store_hold cyc=%0d req=%b we=%b addr=%h wdata=%h isLoad=%b want 1/1/10/3c/0", i, o_memReq, o_memWe, o_memAddr, o_memWdata, o_isLoad);
      end
      if (i == 3) i_memAck = 1'b1;
      tick();
    end
    checks++;
    if (bad) failures++;
    i_memAck = 1'b0;
    checks++;
    if ({o_done, o_memReq, o_isLoad, o_busy, o_fault} !== 5'b10000)
      begin failures++; $display("FAIL store_done done/req/isLoad/busy/fault got=%b want=10000", {o_done, o_memReq, o_isLoad, o_busy, o_fault}); end
    tick();
    checks++;
    if ({o_done, o_isLoad} !== 2'b00) begin failures++; $display("FAIL store_after done/isLoad got=%b want=00", {o_done, o_isLoad}); end
  endtask
  task automatic test_timeout();
    logic bad = 1'b0;
    drive_start(1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 3'd1);
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if ({o_memReq, o_fault} !== 2'b10) begin
        bad = 1'b1;
        $display("FAIL timeout_req cyc=%0d req=%b fault=%b want 1/0", i, o_memReq, o_fault);
      end
      tick();
    end
    checks++;
    if (bad) failures++;
    checks++;
    if ({o_memReq, o_fault, o_isLoad, o_busy, o_done} !== 5'b01000)
      begin failures++; $display("FAIL timeout_abort req/fault/isLoad/busy/done got=%b want=01000", {o_memReq, o_fault, o_isLoad, o_busy, o_done}); end
    tick();
    checks++;
    if ({o_fault, o_busy, o_isLoad, o_done} !== 4'b0000)
      begin failures++; $display("FAIL timeout_after fault/busy/isLoad/done got=%b want=0000", {o_fault, o_busy, o_isLoad, o_done}); end
  endtask
  task automatic test_boundary_ack();
    drive_start(1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 3'd3);
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin i_memAck = 1'b1; i_memRdata = 8'h5A; end
      tick();
    end
    i_memAck = 1'b0;
    checks++;
    if ({o_fault, o_memReq, o_busy} !== 3'b001)
      begin failures++; $display("FAIL boundary_ack fault/req/busy got=%b want=001", {o_fault, o_memReq, o_busy}); end
    tick();
    checks++;
    if ({o_done, o_isLoad, o_addrRw, o_dataIn, o_fault} !== {1'b1, 1'b1, 3'd3, 8'h5A, 1'b0})
      begin failures++; $display("FAIL boundary_wb done=%b isLoad=%b addrRw=%0d dataIn=%h fault=%b want 1/1/3/5a/0", o_done, o_isLoad, o_addrRw, o_dataIn, o_fault); end
  endtask
  task automatic test_back_to_back();
    drive_start(1'b1, 1'b0, 8'h21, 8'h00, 8'h00, 3'd6);
    tick();
    drive_start(1'b0, 1'b0, 8'h55, 8'h00, 8'h99, 3'd0);
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_memReq, o_memWe, o_memAddr} !== {1'b1, 1'b0, 8'h21})
      begin failures++; $display("FAIL busy_reject req=%b we=%b addr=%h want 1/0/21", o_memReq, o_memWe, o_memAddr); end
    i_memAck = 1'b1; i_memRdata = 8'h11;
    tick();
    i_memAck = 1'b0;
    tick();
    checks++;
    if ({o_done, o_isLoad, o_addrRw, o_dataIn} !== {1'b1, 1'b1, 3'd6, 8'h11})
      begin failures++; $display("FAIL reject_wb done=%b isLoad=%b addrRw=%0d dataIn=%h want 1/1/6/11", o_done, o_isLoad, o_addrRw, o_dataIn); end
    drive_start(1'b0, 1'b0, 8'h33, 8'h00, 8'h44, 3'd0);
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_memReq, o_memWe, o_memAddr, o_memWdata} !== {1'b1, 1'b1, 8'h33, 8'h44})
      begin failures++; $display("FAIL start_in_done req=%b we=%b addr=%h wdata=%h want 1/1/33/44", o_memReq, o_memWe, o_memAddr, o_memWdata); end
    i_memAck = 1'b1;
    tick();
    i_memAck = 1'b0;
    checks++;
    if ({o_done, o_isLoad} !== 2'b10) begin failures++; $display("FAIL b2b_store_done done/isLoad got=%b want=10", {o_done, o_isLoad}); end
    drive_start(1'b0, 1'b0, 8'h34, 8'h00, 8'h45, 3'd0);
    tick();
    i_start = 1'b0;
    checks++;
    if ({o_memReq, o_memAddr, o_memWdata} !== {1'b1, 8'h34, 8'h45})
      begin failures++; $display("FAIL b2b_store_next req=%b addr=%h wdata=%h want 1/34/45", o_memReq, o_memAddr, o_memWdata); end
    i_memAck = 1'b1;
    tick();
    i_memAck = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid_req();
    logic bad = 1'b0;
    drive_start(1'b1, 1'b0, 8'h66, 8'h00, 8'h00, 3'd7);
    tick();
    i_start = 1'b0;
    checks++;
    if (o_memReq !== 1'b1) begin failures++; $display("FAIL mid_req_pre req=%b want 1", o_memReq); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 33'd0) begin failures++; $display("FAIL async_reset got=%h want=0", outs()); end
    tick();
    i_rst_n = 1'b1;
    i_memAck = 1'b1; i_memRdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (outs() !== 33'd0) begin
        bad = 1'b1;
        $display("FAIL post_reset_ack cyc=%0d got=%h want=0", i, outs());
      end
    end
    i_memAck = 1'b0;
    checks++;
    if (bad) failures++;
  endtask
  initial begin
    test_reset();
    test_direct_load();
    test_indexed_store();
    test_timeout();
    test_boundary_ack();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
